// File: rtl/intp_ctrl_prio_mask_if.sv
// APB slave bundle for the interrupt controller register file.
// The master modport drives the request side; the slave modport returns the response.
interface intp_ctrl_prio_mask_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic                  psel_i;
   logic                  penable_i;
   logic                  pwrite_i;
   logic [ADDR_WIDTH-1:0] paddr_i;
   logic [DATA_WIDTH-1:0] pwdata_i;
   logic [DATA_WIDTH-1:0] prdata_o;
   logic                  pready_o;
   logic                  perror_o;

   modport master (
      output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
      input  prdata_o, pready_o, perror_o
   );

   modport slave (
      input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
      output prdata_o, pready_o, perror_o
   );
endinterface

// File: rtl/intp_ctrl_prio_mask.sv
// Priority/mask interrupt controller: APB register file, sticky pending latch,
// max-priority arbiter and a presentation FSM that holds valid/ID until serviced.
module intp_ctrl_prio_mask #(
   parameter int NUM_SRC    = 16,
   parameter int PRIO_WIDTH = 4,
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     pclk_i,
   input  logic                     prst_i,
   intp_ctrl_prio_mask_if.slave     apb,
   input  logic [NUM_SRC-1:0]       intp_active_i,
   output logic                     intp_valid_o,
   output logic [ID_WIDTH-1:0]      intp_to_service_o,
   output logic [PRIO_WIDTH-1:0]    intp_prio_o,
   input  logic                     intp_serviced_i
);

   localparam logic [ADDR_WIDTH-1:0] A_ENABLE = ADDR_WIDTH'(NUM_SRC);
   localparam logic [ADDR_WIDTH-1:0] A_MODE   = ADDR_WIDTH'(NUM_SRC + 1);
   localparam logic [ADDR_WIDTH-1:0] A_PEND   = ADDR_WIDTH'(NUM_SRC + 2);
   localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'(NUM_SRC + 3);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(NUM_SRC + 4);

   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_NOTIFY, ST_DONE} state_e;

   logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
   logic [NUM_SRC-1:0]    enable_q, mode_q, pend_q, pend_d, active_q;
   logic [PRIO_WIDTH-1:0] thresh_q;
   state_e                state_q, state_d;
   logic                  valid_q, valid_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [PRIO_WIDTH-1:0] iprio_q, iprio_d;
   logic                  pready_q, pready_d, perror_q, perror_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d, rdata;

   logic                  access, wr_en, addr_ok, svc;
   logic [NUM_SRC-1:0]    elig, w1c_clr, svc_clr;
   logic                  any_elig;
   logic [ID_WIDTH-1:0]   win_id;
   logic [PRIO_WIDTH-1:0] win_prio;
   logic                  unused_pwdata;

   assign unused_pwdata = ^apb.pwdata_i;

   // pready_q gates the access so a held psel/penable is taken only once.
   assign access  = apb.psel_i & apb.penable_i & ~pready_q;
   assign wr_en   = access & apb.pwrite_i;
   assign addr_ok = apb.paddr_i < ADDR_WIDTH'(NUM_SRC + 5);

   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (apb.paddr_i == ADDR_WIDTH'(i)) rdata = DATA_WIDTH'(prio_q[i]);
      end
      if (apb.paddr_i == A_ENABLE) rdata = DATA_WIDTH'(enable_q);
      if (apb.paddr_i == A_MODE)   rdata = DATA_WIDTH'(mode_q);
      if (apb.paddr_i == A_PEND)   rdata = DATA_WIDTH'(pend_q);
      if (apb.paddr_i == A_THRESH) rdata = DATA_WIDTH'(thresh_q);
      if (apb.paddr_i == A_STATUS) rdata = DATA_WIDTH'({valid_q, iprio_q, id_q});
   end

   assign pready_d = access;
   assign perror_d = access & ~addr_ok;
   assign prdata_d = (access && !apb.pwrite_i && addr_ok) ? rdata : '0;

   always_comb begin
      elig     = '0;
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         elig[i] = pend_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
         // Strict compare keeps the lowest index on a priority tie.
         if (elig[i] && (prio_q[i] > win_prio)) begin
            win_id   = ID_WIDTH'(i);
            win_prio = prio_q[i];
         end
      end
   end

   assign any_elig = |elig;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      iprio_d = iprio_q;
      svc     = 1'b0;
      case (state_q)
         ST_IDLE: if (any_elig) state_d = ST_ARB;
         ST_ARB: begin
            if (any_elig) begin
               valid_d = 1'b1;
               id_d    = win_id;
               iprio_d = win_prio;
               state_d = ST_NOTIFY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_NOTIFY: begin
            if (intp_serviced_i) begin
               valid_d = 1'b0;
               id_d    = '0;
               iprio_d = '0;
               svc     = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = any_elig ? ST_ARB : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      svc_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         svc_clr[i] = svc & (id_q == ID_WIDTH'(i));
      end
      w1c_clr = (wr_en && apb.paddr_i == A_PEND) ? apb.pwdata_i[NUM_SRC-1:0] : '0;
      // Edge sources: the rising edge term is OR'd last so a same-cycle set beats any clear.
      pend_d  = (mode_q & ((pend_q & ~(w1c_clr | svc_clr)) | (intp_active_i & ~active_q)))
              | (~mode_q & intp_active_i);
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk_i) begin
      if (prst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         // NOTE: prio_q is a small flop array, not a RAM, so it is cleared like any register.
         for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
         enable_q <= '0;
         mode_q   <= '0;
         pend_q   <= '0;
         active_q <= '0;
         thresh_q <= '0;
         valid_q  <= 1'b0;
         id_q     <= '0;
         iprio_q  <= '0;
         pready_q <= 1'b0;
         perror_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         if (wr_en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (apb.paddr_i == ADDR_WIDTH'(i)) prio_q[i] <= apb.pwdata_i[PRIO_WIDTH-1:0];
            end
            if (apb.paddr_i == A_ENABLE) enable_q <= apb.pwdata_i[NUM_SRC-1:0];
            if (apb.paddr_i == A_MODE)   mode_q   <= apb.pwdata_i[NUM_SRC-1:0];
            if (apb.paddr_i == A_THRESH) thresh_q <= apb.pwdata_i[PRIO_WIDTH-1:0];
         end
         pend_q   <= pend_d;
         active_q <= intp_active_i;
         valid_q  <= valid_d;
         id_q     <= id_d;
         iprio_q  <= iprio_d;
         pready_q <= pready_d;
         perror_q <= perror_d;
         prdata_q <= prdata_d;
      end
   end

   assign apb.prdata_o       = prdata_q;
   assign apb.pready_o       = pready_q;
   assign apb.perror_o       = perror_q;
   assign intp_valid_o       = valid_q;
   assign intp_to_service_o  = id_q;
   assign intp_prio_o        = iprio_q;

endmodule

// File: tb/tb_intp_ctrl_prio_mask.sv
// Self-checking bench: table-driven APB register vectors plus hand-written
// interrupt sequences, with expected responses queued and popped on completion.
module tb_intp_ctrl_prio_mask;

   localparam int NUM_SRC    = 16;
   localparam int PRIO_WIDTH = 4;
   localparam int ID_WIDTH   = 4;
   localparam int ADDR_WIDTH = 6;
   localparam int DATA_WIDTH = 32;
   localparam int A_ENABLE   = NUM_SRC;
   localparam int A_MODE     = NUM_SRC + 1;
   localparam int A_PEND     = NUM_SRC + 2;
   localparam int A_THRESH   = NUM_SRC + 3;
   localparam int A_STATUS   = NUM_SRC + 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_SRC-1:0]    active;
   logic                  serviced;
   logic                  valid;
   logic [ID_WIDTH-1:0]   id;
   logic [PRIO_WIDTH-1:0] prio;

   always #5 clk = ~clk;

   intp_ctrl_prio_mask_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   intp_ctrl_prio_mask #(
      .NUM_SRC(NUM_SRC), .PRIO_WIDTH(PRIO_WIDTH), .ID_WIDTH(ID_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .pclk_i            (clk),
      .prst_i            (rst),
      .apb               (bus),
      .intp_active_i     (active),
      .intp_valid_o      (valid),
      .intp_to_service_o (id),
      .intp_prio_o       (prio),
      .intp_serviced_i   (serviced)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic        wr;
      int          addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   typedef struct {
      string       name;
      logic        is_read;
      logic [31:0] data;
      logic        err;
   } resp_t;

   typedef struct {
      int id;
      int prio;
   } intp_t;

   vec_t  vecs[$];
   resp_t apb_q[$];
   intp_t intp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string name, input logic wr, input int addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
      vec_t v;
      v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
      vecs.push_back(v);
   endtask

   // Full APB transfer; pulse0 raises line 0 during the access phase so it rises on the commit edge.
   task automatic apb(input string name, input logic wr, input int addr, input logic [31:0] wdata,
                      input logic [31:0] want_data, input logic want_err, input logic pulse0);
      resp_t e, r;
      bit    got = 0;
      e.name = name; e.is_read = !wr; e.data = want_data; e.err = want_err;
      apb_q.push_back(e);
      bus.psel_i    = 1'b1;
      bus.penable_i = 1'b0;
      bus.pwrite_i  = wr;
      bus.paddr_i   = ADDR_WIDTH'(addr);
      bus.pwdata_i  = wdata;
      step();
      bus.penable_i = 1'b1;
      if (pulse0) active[0] = 1'b1;
      for (int c = 0; c < 8 && !got; c++) begin
         step();
         if (bus.pready_o) got = 1;
      end
      if (pulse0) active[0] = 1'b0;
      r = apb_q.pop_front();
      if (!got) begin
         check({r.name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({r.name, "_err"}, 32'(bus.perror_o), 32'(r.err));
         if (r.is_read) check({r.name, "_data"}, bus.prdata_o, r.data);
      end
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
   endtask

   task automatic wr(input string name, input int addr, input logic [31:0] d);
      apb(name, 1'b1, addr, d, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic rd(input string name, input int addr, input logic [31:0] want);
      apb(name, 1'b0, addr, 32'd0, want, 1'b0, 1'b0);
   endtask

   task automatic push_intp(input int i, input int p);
      intp_t e;
      e.id = i; e.prio = p;
      intp_q.push_back(e);
   endtask

   // Waits (bounded) for valid, then checks latency (if non-negative), ID and priority.
   task automatic expect_intp(input string name, input int want_lat);
      intp_t e;
      int    cnt = 0;
      while (!valid && cnt < 40) begin
         step();
         cnt++;
      end
      e = intp_q.pop_front();
      if (!valid) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         if (want_lat >= 0) check({name, "_lat"}, 32'(cnt), 32'(want_lat));
         check({name, "_id"}, 32'(id), 32'(e.id));
         check({name, "_prio"}, 32'(prio), 32'(e.prio));
      end
   endtask

   task automatic service();
      serviced = 1'b1;
      step();
      serviced = 1'b0;
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) begin
         apb(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b0);
      end
      vecs.delete();
   endtask

   task automatic load_reset_reads(input string tag);
      for (int a = 0; a <= A_STATUS; a++) begin
         add_vec($sformatf("%s_rd%0d", tag, a), 1'b0, a, 32'd0, 32'd0, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      active        = '0;
      serviced      = 1'b0;
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
      bus.pwrite_i  = 1'b0;
      bus.paddr_i   = '0;
      bus.pwdata_i  = '0;
      repeat (3) step();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_id", 32'(id), 32'd0);
      check("rst_prio", 32'(prio), 32'd0);
      check("rst_pready", 32'(bus.pready_o), 32'd0);
      rst = 1'b0;
      step();

      // Reset readback, illegal addresses, then register width masking.
      load_reset_reads("t1");
      add_vec("t1_bad21",   1'b0, NUM_SRC + 5, 32'd0, 32'd0, 1'b1);
      add_vec("t1_bad63",   1'b0, 63,          32'd0, 32'd0, 1'b1);
      add_vec("t1_badwr",   1'b1, NUM_SRC + 5, 32'h1,  32'd0, 1'b1);
      add_vec("rw_p5_w",    1'b1, 5,        32'hFF,       32'd0,      1'b0);
      add_vec("rw_p5_r",    1'b0, 5,        32'd0,        32'hF,      1'b0);
      add_vec("rw_en_w",    1'b1, A_ENABLE, 32'hFFFF_FFFF, 32'd0,     1'b0);
      add_vec("rw_en_r",    1'b0, A_ENABLE, 32'd0,        32'hFFFF,   1'b0);
      add_vec("rw_th_w",    1'b1, A_THRESH, 32'h3A,       32'd0,      1'b0);
      add_vec("rw_th_r",    1'b0, A_THRESH, 32'd0,        32'hA,      1'b0);
      add_vec("rw_md_w",    1'b1, A_MODE,   32'hFFFF_0001, 32'd0,     1'b0);
      add_vec("rw_md_r",    1'b0, A_MODE,   32'd0,        32'h1,      1'b0);
      add_vec("rw_st_w",    1'b1, A_STATUS, 32'h123,      32'd0,      1'b0);
      add_vec("rw_st_r",    1'b0, A_STATUS, 32'd0,        32'd0,      1'b0);
      add_vec("rw_p5_clr",  1'b1, 5,        32'd0,        32'd0,      1'b0);
      add_vec("rw_en_clr",  1'b1, A_ENABLE, 32'd0,        32'd0,      1'b0);
      add_vec("rw_th_clr",  1'b1, A_THRESH, 32'd0,        32'd0,      1'b0);
      add_vec("rw_md_clr",  1'b1, A_MODE,   32'd0,        32'd0,      1'b0);
      add_vec("rw_md_r0",   1'b0, A_MODE,   32'd0,        32'd0,      1'b0);
      run_vecs();

      // Single level source, 3-cycle latency, status readback, service with line low.
      wr("t2_p3", 3, 32'd5);
      wr("t2_en", A_ENABLE, 32'h0008);
      push_intp(3, 5);
      active[3] = 1'b1;
      expect_intp("t2", 3);
      rd("t2_status", A_STATUS, 32'h153);
      active[3] = 1'b0;
      service();
      check("t2_svc_valid", 32'(valid), 32'd0);
      check("t2_svc_id", 32'(id), 32'd0);
      repeat (4) step();
      check("t2_idle_valid", 32'(valid), 32'd0);

      // Edge sources: tie goes to lowest index, back-to-back delivery, no pre-emption.
      wr("t3_p2", 2, 32'd7);
      wr("t3_p9", 9, 32'd7);
      wr("t3_p4", 4, 32'd3);
      wr("t3_md", A_MODE, 32'h0214);
      wr("t3_en", A_ENABLE, 32'h0214);
      push_intp(2, 7);
      push_intp(9, 7);
      push_intp(4, 3);
      push_intp(9, 7);
      active = 16'h0214;
      step();
      active = '0;
      expect_intp("t3_a", 2);
      service();
      expect_intp("t3_b", 2);
      service();
      expect_intp("t3_c", 2);
      active[9] = 1'b1;
      step();
      active[9] = 1'b0;
      repeat (2) step();
      check("t3_nopreempt_id", 32'(id), 32'd4);
      check("t3_nopreempt_v", 32'(valid), 32'd1);
      service();
      expect_intp("t3_d", 2);
      service();
      repeat (4) step();
      check("t3_idle_valid", 32'(valid), 32'd0);
      rd("t3_pend", A_PEND, 32'd0);

      // Threshold filters priority 5; disabling a presented source does not withdraw it.
      wr("t4_md", A_MODE, 32'd0);
      wr("t4_p1", 1, 32'd5);
      wr("t4_p6", 6, 32'd6);
      wr("t4_th", A_THRESH, 32'd5);
      wr("t4_en", A_ENABLE, 32'h0042);
      push_intp(6, 6);
      active = 16'h0042;
      expect_intp("t4", 3);
      wr("t4_dis", A_ENABLE, 32'd0);
      check("t4_held_valid", 32'(valid), 32'd1);
      check("t4_held_id", 32'(id), 32'd6);
      wr("t4_reen", A_ENABLE, 32'h0042);
      active[6] = 1'b0;
      service();
      repeat (4) step();
      check("t4_idle_valid", 32'(valid), 32'd0);
      rd("t4_pend", A_PEND, 32'h2);
      active[1] = 1'b0;
      repeat (2) step();

      // Edge latch on src 0 while disabled, W1C, and W1C coinciding with a new edge.
      wr("t5_md", A_MODE, 32'h1);
      wr("t5_en", A_ENABLE, 32'd0);
      active[0] = 1'b1;
      step();
      active[0] = 1'b0;
      step();
      rd("t5_pend_set", A_PEND, 32'h1);
      wr("t5_w1c", A_PEND, 32'h1);
      rd("t5_pend_clr", A_PEND, 32'h0);
      apb("t5_w1c_race", 1'b1, A_PEND, 32'h1, 32'd0, 1'b0, 1'b1);
      rd("t5_pend_race", A_PEND, 32'h1);
      check("t5_no_valid", 32'(valid), 32'd0);

      // Reset while presenting clears everything.
      wr("t6_p0", 0, 32'd2);
      wr("t6_th", A_THRESH, 32'd0);
      wr("t6_en", A_ENABLE, 32'h1);
      push_intp(0, 2);
      expect_intp("t6", 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_valid", 32'(valid), 32'd0);
      check("t6_id", 32'(id), 32'd0);
      check("t6_prio", 32'(prio), 32'd0);
      load_reset_reads("t6");
      run_vecs();
      repeat (3) step();
      check("t6_idle_valid", 32'(valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
